// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned ITER_CNT = 32;

    localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on a shared 64-bit accumulator,
// stalling the pipeline via busy and returning a registered result with a one-cycle done pulse.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(ITER_CNT);

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, acc_step;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                accept, is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic                div0, ovf, special, neg_in;
    logic [XLEN-1:0]     abs_a, abs_b, special_res;

    logic [2*XLEN:0]     shifted;
    logic [XLEN:0]       top, sum;
    logic [XLEN-1:0]     diff;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem, final_res;

    // Issue-time operand decode: magnitudes, sign correction flag and special cases.
    always_comb begin
        accept = (state_q == StIdle) & start & ~flush;
        is_div = op[2];
        sgn_a  = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
        sgn_b  = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
        a_neg  = sgn_a & rs1_data[XLEN-1];
        b_neg  = sgn_b & rs2_data[XLEN-1];
        abs_a  = a_neg ? -rs1_data : rs1_data;
        abs_b  = b_neg ? -rs2_data : rs2_data;
        div0   = is_div & (rs2_data == '0);
        ovf    = is_div & ~op[0] & (rs1_data == OVF_Q) & (rs2_data == '1);
        special = FAST_SPECIAL & (div0 | ovf);
        if (div0) begin
            special_res = op[1] ? rs1_data : DIV0_Q;
        end else begin
            special_res = op[1] ? '0 : OVF_Q;
        end
        // A zero divisor must leave the all-ones quotient uncorrected.
        if (!is_div) begin
            neg_in = a_neg ^ b_neg;
        end else if (!op[1]) begin
            neg_in = (a_neg ^ b_neg) & ~div0;
        end else begin
            neg_in = a_neg;
        end
    end

    // One iteration step: shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        shifted  = {acc_q, 1'b0};
        top      = shifted[2*XLEN:XLEN];
        diff     = top[XLEN-1:0] - b_q;
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        acc_step = acc_q;
        if (op_q[2]) begin
            if (top >= {1'b0, b_q}) begin
                acc_step = {diff, shifted[XLEN-1:1], 1'b1};
            end else begin
                acc_step = shifted[2*XLEN-1:0];
            end
        end else begin
            acc_step = {sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and word selection on the final accumulator value.
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quot = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                       final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quot;
            default:                      final_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = op;
                    b_d     = abs_b;
                    acc_d   = {{XLEN{1'b0}}, abs_a};
                    neg_d   = neg_in;
                    count_d = '0;
                    if (special) begin
                        state_d  = StDone;
                        result_d = special_res;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d   = acc_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CntW'(ITER_CNT - 1)) begin
                        state_d  = StDone;
                        result_d = final_res;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // busy is combinational so the issuing instruction is held from its first EX cycle.
    assign busy   = ~rst & ((state_q == StCalc) | accept);
    assign done   = (state_q == StDone) & ~flush;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed spec cases, flush/reset scenarios and
// randomized operations against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_pass;
    int n_total;

    ex_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // RISC-V M-extension results from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        up = {32'b0, a} * {32'b0, b};
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one operation and check busy, latency, done pulse and result hold.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        bit busy_ok;
        bit fast;
        fast     = is_fast(o, a, b);
        op       = o;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        #1;
        check($sformatf("%s busy_at_issue", tag), {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s latency", tag), lat, fast ? 32'd1 : 32'd33);
        if (!fast) check($sformatf("%s busy_in_calc", tag), {31'b0, busy_ok}, 32'd1);
        check($sformatf("%s done", tag), {31'b0, done}, 32'd1);
        check($sformatf("%s busy_at_done", tag), {31'b0, busy}, 32'd0);
        check($sformatf("%s result", tag), result, exp);
        @(posedge clk);
        #1;
        check($sformatf("%s done_one_cycle", tag), {31'b0, done}, 32'd0);
        check($sformatf("%s result_hold", tag), result, exp);
    endtask

    initial begin
        logic [31:0] prev;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        bit          saw_done;
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        start    = 1'b1;
        op       = 3'd0;
        rs1_data = 32'd3;
        rs2_data = 32'd4;
        flush    = 1'b0;
        #3;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("post_reset busy", {31'b0, busy}, 32'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_by0");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
        run_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, "mul_pos");
        prev = 32'd7006652;

        // Flush at CALC cycle 10.
        op       = 3'd5;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush result_kept", result, prev);
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("flush no_done", {31'b0, saw_done}, 32'd0);
        check("flush result_still", result, prev);
        run_op(3'd5, 32'd1000, 32'd3, 32'd333, "after_flush");

        // start and flush together in IDLE.
        op       = 3'd0;
        rs1_data = 32'd9;
        rs2_data = 32'd9;
        start    = 1'b1;
        flush    = 1'b1;
        #1;
        check("start_flush busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("start_flush not_accepted", {31'b0, busy}, 32'd0);
        check("start_flush done", {31'b0, done}, 32'd0);

        // Asynchronous reset in the middle of CALC.
        op       = 3'd0;
        rs1_data = 32'd77;
        rs2_data = 32'd88;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst busy", {31'b0, busy}, 32'd0);
        check("async_rst done", {31'b0, done}, 32'd0);
        check("async_rst result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst idle", {31'b0, busy}, 32'd0);
        run_op(3'd0, 32'd77, 32'd88, 32'd6776, "after_rst");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
